// File: rtl/mdu_iter.sv
// Iterative RV32M multiply/divide unit: shift-add multiplier and restoring divider on one datapath.
// Define MDU_FAST_MUL_EN to compute multiplies in a single cycle with a wide multiplier.
module mdu_iter #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned CNT_W = 6
) (
    input  logic            clock_i,
    input  logic            reset_i,
    input  logic            start_i,
    input  logic [2:0]      op_i,
    input  logic [XLEN-1:0] a_i,
    input  logic [XLEN-1:0] b_i,
    output logic [XLEN-1:0] result_o,
    output logic            done_o,
    output logic            busy_o,
    output logic            stall_o
);

    typedef enum logic [1:0] {StIdle, StRun, StFix, StDone} state_e;

    localparam logic [XLEN-1:0] MinNeg = {1'b1, {(XLEN-1){1'b0}}};

    state_e            state_q, state_d;
    logic [XLEN-1:0]   hi_q, hi_d, lo_q, lo_d, opnd_q, opnd_d, result_q, result_d;
    logic [2:0]        op_q, op_d;
    logic              neg_q, neg_d, rneg_q, rneg_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    logic              a_sgn, b_sgn, a_neg, b_neg;
    logic [XLEN-1:0]   a_mag, b_mag, mul_add, quo_fix, rem_fix, fix_res;
    logic [XLEN:0]     mul_sum, div_shift, div_diff;
    logic [2*XLEN-1:0] prod_fix;

    assign a_sgn = op_i inside {3'b001, 3'b010, 3'b100, 3'b110};
    assign b_sgn = op_i inside {3'b001, 3'b100, 3'b110};
    assign a_neg = a_sgn & a_i[XLEN-1];
    assign b_neg = b_sgn & b_i[XLEN-1];
    assign a_mag = a_neg ? -a_i : a_i;
    assign b_mag = b_neg ? -b_i : b_i;

    // hi_q holds the product high word / partial remainder, lo_q the multiplier / quotient.
    assign mul_add   = lo_q[0] ? opnd_q : {XLEN{1'b0}};
    assign mul_sum   = {1'b0, hi_q} + {1'b0, mul_add};
    assign div_shift = {hi_q, lo_q[XLEN-1]};
    assign div_diff  = div_shift - {1'b0, opnd_q};

    assign prod_fix = neg_q ? -{hi_q, lo_q} : {hi_q, lo_q};
    assign quo_fix  = neg_q ? -lo_q : lo_q;
    assign rem_fix  = rneg_q ? -hi_q : hi_q;

`ifdef MDU_FAST_MUL_EN
    logic [2*XLEN-1:0] fast_prod, fast_fix;
    logic [XLEN-1:0]   fast_res;
    assign fast_prod = {{XLEN{1'b0}}, a_mag} * {{XLEN{1'b0}}, b_mag};
    assign fast_fix  = (a_neg ^ b_neg) ? -fast_prod : fast_prod;
    assign fast_res  = (op_i[1:0] == 2'b00) ? fast_fix[XLEN-1:0] : fast_fix[2*XLEN-1:XLEN];
`endif

    always_comb begin
        fix_res = lo_q;
        unique case (op_q)
            3'b000:                 fix_res = prod_fix[XLEN-1:0];
            3'b001, 3'b010, 3'b011: fix_res = prod_fix[2*XLEN-1:XLEN];
            3'b100, 3'b101:         fix_res = quo_fix;
            3'b110, 3'b111:         fix_res = rem_fix;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        opnd_d   = opnd_q;
        result_d = result_q;
        op_d     = op_q;
        neg_d    = neg_q;
        rneg_d   = rneg_q;
        cnt_d    = cnt_q;
        unique case (state_q)
            StIdle: begin
                if (start_i) begin
                    op_d    = op_i;
                    neg_d   = a_neg ^ b_neg;
                    rneg_d  = a_neg;
                    cnt_d   = '0;
                    hi_d    = '0;
                    lo_d    = op_i[2] ? a_mag : b_mag;
                    opnd_d  = op_i[2] ? b_mag : a_mag;
                    state_d = StRun;
                    if (op_i[2] && (b_i == '0)) begin
                        state_d  = StDone;
                        result_d = op_i[1] ? a_i : '1;
                    end else if ((op_i[2:1] != 2'b01) && op_i[2] && !op_i[0] &&
                                 (a_i == MinNeg) && (b_i == '1)) begin
                        // Signed overflow: quotient wraps to MinNeg, remainder is zero
                        state_d  = StDone;
                        result_d = op_i[1] ? '0 : MinNeg;
                    end
`ifdef MDU_FAST_MUL_EN
                    else if (!op_i[2]) begin
                        state_d  = StDone;
                        result_d = fast_res;
                    end
`endif
                end
            end
            StRun: begin
                cnt_d = cnt_q + 1'b1;
                if (op_q[2]) begin
                    if (!div_diff[XLEN]) begin
                        hi_d = div_diff[XLEN-1:0];
                        lo_d = {lo_q[XLEN-2:0], 1'b1};
                    end else begin
                        hi_d = div_shift[XLEN-1:0];
                        lo_d = {lo_q[XLEN-2:0], 1'b0};
                    end
                end else begin
                    hi_d = mul_sum[XLEN:1];
                    lo_d = {mul_sum[0], lo_q[XLEN-1:1]};
                end
                if (cnt_q == CNT_W'(XLEN - 1)) state_d = StFix;
            end
            StFix: begin
                result_d = fix_res;
                state_d  = StDone;
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            state_q  <= StIdle;
            hi_q     <= '0;
            lo_q     <= '0;
            opnd_q   <= '0;
            result_q <= '0;
            op_q     <= '0;
            neg_q    <= 1'b0;
            rneg_q   <= 1'b0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            opnd_q   <= opnd_d;
            result_q <= result_d;
            op_q     <= op_d;
            neg_q    <= neg_d;
            rneg_q   <= rneg_d;
            cnt_q    <= cnt_d;
        end
    end

    assign result_o = result_q;
    assign done_o   = (state_q == StDone);
    assign busy_o   = (state_q == StRun) || (state_q == StFix);
    assign stall_o  = ((state_q == StIdle) && start_i) || busy_o;

endmodule

// File: tb/tb_mdu_iter.sv
// Self-checking bench for mdu_iter: vector table plus scoreboard queue, and hand-written
// sequences for ignored restarts and mid-operation reset.
module tb_mdu_iter;

    localparam int unsigned XLEN = 32;
`ifdef MDU_FAST_MUL_EN
    localparam int MulLat = 1;
`else
    localparam int MulLat = 34;
`endif

    logic            clock = 1'b0;
    logic            reset, start;
    logic [2:0]      op;
    logic [XLEN-1:0] a, b, result;
    logic            done, busy, stall;

    int errors = 0;
    int checks = 0;
    logic [XLEN-1:0] exp_q[$];

    typedef struct {
        logic [2:0]      op;
        logic [XLEN-1:0] a;
        logic [XLEN-1:0] b;
        logic [XLEN-1:0] res;
        int              lat;
    } vec_t;
    vec_t vecs[$];

    always #5 clock = ~clock;

    mdu_iter #(.XLEN(XLEN), .CNT_W(6)) dut (
        .clock_i (clock),
        .reset_i (reset),
        .start_i (start),
        .op_i    (op),
        .a_i     (a),
        .b_i     (b),
        .result_o(result),
        .done_o  (done),
        .busy_o  (busy),
        .stall_o (stall)
    );

    task automatic check(input string name, input logic [XLEN-1:0] got, input logic [XLEN-1:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, want);
        end
    endtask

    task automatic run_op(input string name, input logic [2:0] o, input logic [XLEN-1:0] x,
                          input logic [XLEN-1:0] y, input logic [XLEN-1:0] want, input int lat);
        int n  = 0;
        int st = 0;
        logic [XLEN-1:0] w;
        @(negedge clock);
        op = o; a = x; b = y; start = 1'b1;
        exp_q.push_back(want);
        forever begin
            #1;
            if (stall === 1'b1) st++;
            @(posedge clock);
            #1;
            start = 1'b0;
            n++;
            if (done === 1'b1 || n >= 200) break;
            @(negedge clock);
        end
        check({name, " done"}, {31'b0, done}, 32'd1);
        w = exp_q.pop_front();
        check({name, " result"}, result, w);
        check({name, " latency"}, 32'(n), 32'(lat));
        check({name, " stall"}, 32'(st), 32'(lat));
        @(posedge clock);
        #1;
        check({name, " done pulse"}, {31'b0, done}, 32'd0);
    endtask

    initial begin
        int dones;
        logic [XLEN-1:0] w;
        reset = 1'b1; start = 1'b0; op = '0; a = '0; b = '0;
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b0;
        check("reset result", result, 32'd0);
        check("reset done", {31'b0, done}, 32'd0);
        check("reset busy", {31'b0, busy}, 32'd0);
        check("reset stall", {31'b0, stall}, 32'd0);

        vecs.push_back('{3'b000, 32'd7, 32'hFFFFFFFD, 32'hFFFFFFEB, MulLat});
        vecs.push_back('{3'b001, 32'd7, 32'hFFFFFFFD, 32'hFFFFFFFF, MulLat});
        vecs.push_back('{3'b011, 32'd7, 32'hFFFFFFFD, 32'h00000006, MulLat});
        vecs.push_back('{3'b010, 32'd7, 32'hFFFFFFFD, 32'h00000006, MulLat});
        vecs.push_back('{3'b010, 32'hFFFFFFFF, 32'd2, 32'hFFFFFFFF, MulLat});
        vecs.push_back('{3'b001, 32'h80000000, 32'h80000000, 32'h40000000, MulLat});
        vecs.push_back('{3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, MulLat});
        vecs.push_back('{3'b000, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, MulLat});
        vecs.push_back('{3'b100, 32'hFFFFFFEC, 32'd3, 32'hFFFFFFFA, 34});
        vecs.push_back('{3'b110, 32'hFFFFFFEC, 32'd3, 32'hFFFFFFFE, 34});
        vecs.push_back('{3'b101, 32'd20, 32'd3, 32'd6, 34});
        vecs.push_back('{3'b111, 32'd20, 32'd3, 32'd2, 34});
        vecs.push_back('{3'b100, 32'd7, 32'hFFFFFFFE, 32'hFFFFFFFD, 34});
        vecs.push_back('{3'b110, 32'd7, 32'hFFFFFFFE, 32'd1, 34});
        vecs.push_back('{3'b101, 32'd100, 32'd7, 32'd14, 34});
        vecs.push_back('{3'b101, 32'hFFFFFFFF, 32'd1, 32'hFFFFFFFF, 34});
        vecs.push_back('{3'b100, 32'h80000000, 32'd1, 32'h80000000, 34});
        vecs.push_back('{3'b111, 32'hFFFFFFFF, 32'h10, 32'h0000000F, 34});
        vecs.push_back('{3'b101, 32'd5, 32'd0, 32'hFFFFFFFF, 1});
        vecs.push_back('{3'b110, 32'd5, 32'd0, 32'd5, 1});
        vecs.push_back('{3'b100, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1});
        vecs.push_back('{3'b110, 32'h80000000, 32'hFFFFFFFF, 32'd0, 1});
        vecs.push_back('{3'b101, 32'h80000000, 32'hFFFFFFFF, 32'd0, 34});

        foreach (vecs[i])
            run_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].res, vecs[i].lat);

        // Restart attempt mid-RUN must be ignored
        @(negedge clock);
        op = 3'b101; a = 32'd100; b = 32'd7; start = 1'b1;
        exp_q.push_back(32'd14);
        @(posedge clock);
        #1;
        start = 1'b0;
        dones = 0;
        repeat (10) @(posedge clock);
        @(negedge clock);
        op = 3'b000; a = 32'd6; b = 32'd7; start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        for (int c = 0; c < 100; c++) begin
            @(posedge clock);
            #1;
            if (done === 1'b1) begin
                dones++;
                if (exp_q.size() > 0) begin
                    w = exp_q.pop_front();
                    check("restart result", result, w);
                end
            end
        end
        check("restart done count", 32'(dones), 32'd1);
        check("restart result hold", result, 32'd14);
        check("restart busy", {31'b0, busy}, 32'd0);

        // Reset mid-RUN discards the operation
        @(negedge clock);
        op = 3'b101; a = 32'd100; b = 32'd7; start = 1'b1;
        @(posedge clock);
        #1;
        start = 1'b0;
        repeat (15) @(posedge clock);
        @(negedge clock);
        reset = 1'b1;
        @(posedge clock);
        #1;
        reset = 1'b0;
        check("midreset result", result, 32'd0);
        check("midreset busy", {31'b0, busy}, 32'd0);
        check("midreset stall", {31'b0, stall}, 32'd0);
        check("midreset done", {31'b0, done}, 32'd0);
        dones = 0;
        for (int c = 0; c < 40; c++) begin
            @(posedge clock);
            #1;
            if (done === 1'b1 || busy === 1'b1) dones++;
        end
        check("midreset quiet", 32'(dones), 32'd0);
        run_op("mul 6x7", 3'b000, 32'd6, 32'd7, 32'd42, MulLat);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
